// File: rtl/alu_seq_responder.sv
// Handshaked multi-cycle MIPS ALU responder: one request per valid/ready transfer,
// iterative shifts of SHIFT_STEP bits per cycle, result held until the consumer takes it.
module alu_seq_responder #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instruction,
  input  logic [31:0] regA,
  input  logic [31:0] regB,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [2:0]  flags,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shift_t;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  state_t      state_q, state_d;
  shift_t      kind_q, alu_kind;
  logic [31:0] shreg_q, shifted;
  logic [4:0]  remaining_q, step;
  logic        last_step;

  logic [5:0]  op, funct;
  logic [4:0]  shamt;
  logic [31:0] simm, zimm;
  logic [31:0] sum_ab, diff_ab, sum_ai;
  logic [31:0] alu_res;
  logic [2:0]  alu_flags;
  logic        alu_ill, alu_ov, alu_cmp, alu_is_cmp, alu_is_shift;
  logic [4:0]  alu_amt;
  logic        unused_fields;

  assign op            = instruction[31:26];
  assign funct         = instruction[5:0];
  assign shamt         = instruction[10:6];
  assign simm          = {{16{instruction[15]}}, instruction[15:0]};
  assign zimm          = {16'h0000, instruction[15:0]};
  assign unused_fields = ^instruction[25:16];

  assign sum_ab  = regA + regB;
  assign diff_ab = regA - regB;
  assign sum_ai  = regA + simm;

  // Single-cycle ops are evaluated straight from the request inputs and captured on the transfer edge.
  always_comb begin
    alu_res      = '0;
    alu_ov       = 1'b0;
    alu_ill      = 1'b0;
    alu_cmp      = 1'b0;
    alu_is_cmp   = 1'b0;
    alu_is_shift = 1'b0;
    alu_kind     = SH_LL;
    alu_amt      = '0;
    case (op)
      6'h00: begin
        case (funct)
          6'h20: begin
            alu_res = sum_ab;
            alu_ov  = (regA[31] == regB[31]) && (sum_ab[31] != regA[31]);
          end
          6'h21: alu_res = sum_ab;
          6'h22: begin
            alu_res = diff_ab;
            alu_ov  = (regA[31] != regB[31]) && (diff_ab[31] != regA[31]);
          end
          6'h23: alu_res = diff_ab;
          6'h24: alu_res = regA & regB;
          6'h25: alu_res = regA | regB;
          6'h26: alu_res = regA ^ regB;
          6'h27: alu_res = ~(regA | regB);
          6'h2A: begin alu_is_cmp = 1'b1; alu_cmp = $signed(regA) < $signed(regB); end
          6'h2B: begin alu_is_cmp = 1'b1; alu_cmp = regA < regB; end
          6'h00: begin alu_is_shift = 1'b1; alu_kind = SH_LL; alu_amt = shamt;     end
          6'h02: begin alu_is_shift = 1'b1; alu_kind = SH_RL; alu_amt = shamt;     end
          6'h03: begin alu_is_shift = 1'b1; alu_kind = SH_RA; alu_amt = shamt;     end
          6'h04: begin alu_is_shift = 1'b1; alu_kind = SH_LL; alu_amt = regB[4:0]; end
          6'h06: begin alu_is_shift = 1'b1; alu_kind = SH_RL; alu_amt = regB[4:0]; end
          6'h07: begin alu_is_shift = 1'b1; alu_kind = SH_RA; alu_amt = regB[4:0]; end
          default: alu_ill = 1'b1;
        endcase
      end
      6'h08: begin
        alu_res = sum_ai;
        alu_ov  = (regA[31] == simm[31]) && (sum_ai[31] != regA[31]);
      end
      6'h09, 6'h23, 6'h2B: alu_res = sum_ai;
      6'h0A: begin alu_is_cmp = 1'b1; alu_cmp = $signed(regA) < $signed(simm); end
      6'h0B: begin alu_is_cmp = 1'b1; alu_cmp = regA < simm; end
      6'h0C: alu_res = regA & zimm;
      6'h0D: alu_res = regA | zimm;
      6'h0E: alu_res = regA ^ zimm;
      6'h04, 6'h05: alu_res = diff_ab;
      default: alu_ill = 1'b1;
    endcase
    if (alu_is_cmp)   alu_res = {31'b0, alu_cmp};
    if (alu_is_shift) alu_res = regA;
    if (alu_ill)
      alu_flags = '0;
    else
      alu_flags = {alu_res == '0, alu_is_cmp ? alu_cmp : alu_res[31], alu_ov};
  end

  // The final shift step consumes only what is left of the amount.
  always_comb begin
    last_step = (remaining_q <= STEP);
    step      = last_step ? remaining_q : STEP;
    case (kind_q)
      SH_RL:   shifted = shreg_q >> step;
      SH_RA:   shifted = 32'($signed(shreg_q) >>> step);
      default: shifted = shreg_q << step;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_d = (alu_is_shift && alu_amt != '0) ? SHIFT : DONE;
      end
      SHIFT: if (last_step) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result      <= '0;
      flags       <= '0;
      illegal     <= 1'b0;
      shreg_q     <= '0;
      remaining_q <= '0;
      kind_q      <= SH_LL;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          if (alu_is_shift && alu_amt != '0) begin
            shreg_q     <= regA;
            remaining_q <= alu_amt;
            kind_q      <= alu_kind;
          end else begin
            result  <= alu_res;
            flags   <= alu_flags;
            illegal <= alu_ill;
          end
        end
        SHIFT: begin
          shreg_q     <= shifted;
          remaining_q <= remaining_q - step;
          if (last_step) begin
            result  <= shifted;
            flags   <= {shifted == '0, shifted[31], 1'b0};
            illegal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_responder.sv
// Directed bench for alu_seq_responder: two instances (SHIFT_STEP 1 and 4) share stimulus,
// each response checked against hand-computed values and latencies.
module tb_alu_seq_responder;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready;
  logic [31:0] instruction, regA, regB;
  logic        in_ready1, out_valid1, illegal1;
  logic        in_ready4, out_valid4, illegal4;
  logic [31:0] result1, result4;
  logic [2:0]  flags1, flags4;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  alu_seq_responder #(.SHIFT_STEP(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .instruction(instruction), .regA(regA), .regB(regB),
    .out_valid(out_valid1), .out_ready(out_ready),
    .result(result1), .flags(flags1), .illegal(illegal1)
  );

  alu_seq_responder #(.SHIFT_STEP(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .instruction(instruction), .regA(regA), .regB(regB),
    .out_valid(out_valid4), .out_ready(out_ready),
    .result(result4), .flags(flags4), .illegal(illegal4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] funct, input logic [4:0] sh);
    return {6'h00, 15'h0000, sh, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'h000, imm};
  endfunction

  // Issue one request, measure latency on both instances, check the held response.
  task automatic xact(input string tag, input logic [31:0] ins, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] er, input logic [2:0] ef,
                      input logic ei, input int l1, input int l4, input bit rel);
    int n, got1, got4;
    @(negedge clk);
    check({tag, ":in_ready"}, {31'b0, in_ready1 & in_ready4}, 32'd1);
    instruction = ins; regA = a; regB = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1; got1 = 0; got4 = 0;
    if (out_valid1) got1 = n;
    if (out_valid4) got4 = n;
    while ((got1 == 0 || got4 == 0) && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (out_valid1 && got1 == 0) got1 = n;
      if (out_valid4 && got4 == 0) got4 = n;
    end
    check({tag, ":lat1"},    got1, l1);
    check({tag, ":lat4"},    got4, l4);
    check({tag, ":result1"}, result1, er);
    check({tag, ":flags1"},  {29'b0, flags1}, {29'b0, ef});
    check({tag, ":illegal1"}, {31'b0, illegal1}, {31'b0, ei});
    check({tag, ":result4"}, result4, er);
    check({tag, ":flags4"},  {29'b0, flags4}, {29'b0, ef});
    check({tag, ":illegal4"}, {31'b0, illegal4}, {31'b0, ei});
    if (rel) begin
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
    end
  endtask

  initial begin
    int stale;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    instruction = '0; regA = '0; regB = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst:out_valid", {31'b0, out_valid1 | out_valid4}, 32'd0);
    check("rst:result",    result1 | result4, 32'd0);
    check("rst:flags",     {29'b0, flags1 | flags4}, 32'd0);
    check("rst:illegal",   {31'b0, illegal1 | illegal4}, 32'd0);
    check("rst:in_ready",  {31'b0, in_ready1 & in_ready4}, 32'd1);
    reset = 1'b0;

    xact("add",   rtype(6'h20, 5'd0), 32'h7FFFFFFF, 32'd1, 32'h80000000, 3'b011, 1'b0, 1, 1, 1);
    xact("addu",  rtype(6'h21, 5'd0), 32'h7FFFFFFF, 32'd1, 32'h80000000, 3'b010, 1'b0, 1, 1, 1);
    xact("sub",   rtype(6'h22, 5'd0), -32'sd30, -32'sd31, 32'd1, 3'b000, 1'b0, 1, 1, 1);
    xact("subov", rtype(6'h22, 5'd0), 32'h80000000, 32'd1, 32'h7FFFFFFF, 3'b001, 1'b0, 1, 1, 1);
    xact("beq",   itype(6'h04, 16'h0000), 32'd10, 32'd10, 32'd0, 3'b100, 1'b0, 1, 1, 1);
    xact("sra",   rtype(6'h03, 5'd10), 32'hF0000000, 32'd0, 32'hFFFC0000, 3'b010, 1'b0, 11, 4, 1);
    xact("sllv",  rtype(6'h04, 5'd0), 32'd1, 32'd5, 32'h00000020, 3'b000, 1'b0, 6, 3, 1);
    xact("srlv0", rtype(6'h06, 5'd0), 32'h80000001, 32'd32, 32'h80000001, 3'b010, 1'b0, 1, 1, 1);
    xact("sltiu", itype(6'h0B, 16'hFFFF), 32'd20, 32'd0, 32'd1, 3'b010, 1'b0, 1, 1, 1);
    xact("andi",  itype(6'h0C, 16'h000C), 32'h0000000C, 32'd0, 32'h0000000C, 3'b000, 1'b0, 1, 1, 1);
    xact("slt",   rtype(6'h2A, 5'd0), 32'hFFFFFFFF, 32'd1, 32'd1, 3'b010, 1'b0, 1, 1, 1);
    xact("nor",   rtype(6'h27, 5'd0), 32'd0, 32'd0, 32'hFFFFFFFF, 3'b010, 1'b0, 1, 1, 1);
    xact("lw",    itype(6'h23, 16'hFFFC), 32'h00000100, 32'd0, 32'h000000FC, 3'b000, 1'b0, 1, 1, 1);
    xact("badfn", rtype(6'h01, 5'd0), 32'h12345678, 32'h1, 32'd0, 3'b000, 1'b1, 1, 1, 1);

    // Backpressure: response held while a second request waits.
    xact("hold1", rtype(6'h20, 5'd0), 32'd100, 32'd23, 32'd123, 3'b000, 1'b0, 1, 1, 0);
    @(negedge clk);
    instruction = itype(6'h0D, 16'h000F); regA = 32'hF0; regB = 32'd0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold:result",    result1, 32'd123);
      check("hold:out_valid", {31'b0, out_valid1 & out_valid4}, 32'd1);
      check("hold:in_ready",  {31'b0, in_ready1 | in_ready4}, 32'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("rel:out_valid", {31'b0, out_valid1 | out_valid4}, 32'd0);
    check("rel:in_ready",  {31'b0, in_ready1 & in_ready4}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ori:out_valid", {31'b0, out_valid1 & out_valid4}, 32'd1);
    check("ori:result1",   result1, 32'h000000FF);
    check("ori:result4",   result4, 32'h000000FF);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;

    // Reset in the middle of a long shift must discard it.
    @(negedge clk);
    instruction = rtype(6'h00, 5'd20); regA = 32'd1; regB = 32'd0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    check("abort:out_valid", {31'b0, out_valid1 | out_valid4}, 32'd0);
    check("abort:result",    result1 | result4, 32'd0);
    check("abort:in_ready",  {31'b0, in_ready1 & in_ready4}, 32'd1);
    stale = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid1 || out_valid4) stale++;
    end
    check("abort:stale", stale, 32'd0);
    xact("op3f", itype(6'h3F, 16'h1234), 32'hDEADBEEF, 32'h1, 32'd0, 3'b000, 1'b1, 1, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
